// File: rtl/alu_mul_seq.sv
// alu_mul_seq -- sequential unsigned shift-add multiplier that borrows a
// shared, registered ALU (6502-style) for every addition and shift.
//
// Each of the dw iterations takes three cycles:
//   ADD   : ALU computes P + (Q[0] ? M : 0)
//   SHIFT : ALU shifts {carry, sum} right by one. The add carry enters
//           the top bit and the sum LSB leaves on CO.
//   WB    : P takes the shifted sum and Q shifts right, taking in that LSB.
// The product {P,Q} is valid one cycle later, in DONE.
//
// Ports:
//   clk, reset_n   clock and synchronous active-low reset
//   RDY            global stall; all state freezes while low
//   start          multiply request, sampled only in IDLE
//   A, B           multiplicand / multiplier (dw bits)
//   busy, done     busy in ADD/SHIFT/WB; done strobes for one cycle in DONE
//   PROD           {P,Q}, 2*dw bits, held until the next accepted start
//   alu_*          drive/response of the shared ALU (alu_OUT and alu_CO are
//                  that ALU's registered results)
module alu_mul_seq #(
  parameter int dw = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            RDY,
  input  logic            start,
  input  logic [dw-1:0]   A,
  input  logic [dw-1:0]   B,
  output logic            busy,
  output logic            done,
  output logic [2*dw-1:0] PROD,
  output logic [3:0]      alu_op,
  output logic            alu_right,
  output logic [dw-1:0]   alu_AI,
  output logic [dw-1:0]   alu_BI,
  output logic            alu_CI,
  output logic            alu_RDY,
  input  logic [dw-1:0]   alu_OUT,
  input  logic            alu_CO
);

  localparam int CW = $clog2(dw) + 1;

  localparam logic [3:0] OP_ADD  = 4'b0011;  // AI + BI + CI
  localparam logic [3:0] OP_PASS = 4'b1111;  // AI + CI (BI forced to zero)

  typedef enum logic [2:0] {IDLE, ADD, SHIFT, WB, DONE} state_t;

  state_t        state;
  logic [dw-1:0] m_reg;
  logic [dw-1:0] p_reg;
  logic [dw-1:0] q_reg;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      m_reg <= '0;
      p_reg <= '0;
      q_reg <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (RDY) begin
      case (state)
        IDLE: begin
          if (start) begin
            m_reg <= A;
            p_reg <= '0;
            q_reg <= B;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ADD;
          end
        end
        ADD:   state <= SHIFT;
        SHIFT: state <= WB;
        WB: begin
          // The ALU now holds the shifted sum: OUT is the new P, and CO is
          // the bit that drops into the top of Q.
          p_reg <= alu_OUT;
          q_reg <= {alu_CO, q_reg[dw-1:1]};
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(dw - 1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= ADD;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // The ALU registers its result, so SHIFT must feed it alu_OUT/alu_CO from
  // the same cycle. That makes the ALU drive a combinational decode of state.
  always_comb begin
    alu_op    = OP_PASS;
    alu_right = 1'b0;
    alu_AI    = '0;
    alu_BI    = '0;
    alu_CI    = 1'b0;
    case (state)
      ADD: begin
        alu_AI = p_reg;
        if (q_reg[0]) begin
          alu_op = OP_ADD;
          alu_BI = m_reg;
        end
      end
      SHIFT: begin
        alu_right = 1'b1;
        alu_AI    = alu_OUT;
        alu_CI    = alu_CO;
      end
      default: ;
    endcase
  end

  assign alu_RDY = RDY;
  assign PROD    = {p_reg, q_reg};

endmodule

// File: tb/tb_alu_mul_seq.sv
// Testbench for alu_mul_seq (dw=16). It contains a behavioural model of the
// shared registered ALU, a table of directed multiply vectors, and hand-written
// sequences for reset, start-held and mid-operation reset cases.
module tb_alu_mul_seq;

  logic        clk;
  logic        reset_n;
  logic        RDY;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        busy;
  logic        done;
  logic [31:0] PROD;
  logic [3:0]  alu_op;
  logic        alu_right;
  logic [15:0] alu_AI;
  logic [15:0] alu_BI;
  logic        alu_CI;
  logic        alu_RDY;
  logic [15:0] alu_OUT;
  logic        alu_CO;

  int checks   = 0;
  int failures = 0;

  alu_mul_seq #(.dw(16)) dut (
    .clk(clk), .reset_n(reset_n), .RDY(RDY), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .PROD(PROD), .alu_op(alu_op),
    .alu_right(alu_right), .alu_AI(alu_AI), .alu_BI(alu_BI), .alu_CI(alu_CI),
    .alu_RDY(alu_RDY), .alu_OUT(alu_OUT), .alu_CO(alu_CO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the shared ALU: it registers its result and is clock-enabled
  // by alu_RDY.
  // Right shift: OUT={CI,AI[15:1]}, CO=AI[0]. Add: {CO,OUT}=AI+BI'+CI.
  always @(posedge clk) begin
    if (alu_RDY) begin
      if (alu_right) begin
        alu_OUT <= {alu_CI, alu_AI[15:1]};
        alu_CO  <= alu_AI[0];
      end else begin
        {alu_CO, alu_OUT} <= {1'b0, alu_AI} +
                             {1'b0, (alu_op == 4'b0011) ? alu_BI : 16'h0} +
                             {16'h0, alu_CI};
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Starts a multiply in the current cycle (cycle 0) and follows it to DONE.
  // It checks the ALU drive in every ADD and SHIFT cycle when there is no
  // stall, then the done cycle, the product, and the cycle after DONE.
  task automatic run_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp, input int exp_cyc,
                        input int stall_at, input int stall_len, input bit hold);
    int dc;
    int k;
    dc = -1;
    A = a; B = b; start = 1'b1; RDY = 1'b1;
    for (int n = 1; n <= 120 && dc < 0; n++) begin
      tick();
      if (!hold) start = 1'b0;
      if (hold && n == 10) begin A = 16'hAAAA; B = 16'h5555; end
      if (done) dc = n;
      else if (stall_len == 0 && n < 49 && (n - 1) % 3 == 0) begin
        k = (n - 1) / 3;
        chk({nm, " add_drive"}, {alu_op, alu_right, alu_CI, alu_BI},
            {(b[k] ? 4'b0011 : 4'b1111), 1'b0, 1'b0, (b[k] ? a : 16'h0)});
      end else if (stall_len == 0 && n < 49 && (n - 2) % 3 == 0) begin
        chk({nm, " shift_drive"}, {alu_op, alu_right, alu_BI, alu_AI},
            {4'b1111, 1'b1, 16'h0, alu_OUT});
      end
      if (stall_len != 0 && n == stall_at + 2)
        chk({nm, " busy_in_stall"}, {busy, alu_right}, {1'b1, 1'b1});
      RDY = !(n >= stall_at && n < stall_at + stall_len);
    end
    RDY = 1'b1;
    if (dc < 0) begin
      failures++;
      checks++;
      $display("FAIL %s done_timeout actual=none required=%0d", nm, exp_cyc);
    end else begin
      chk({nm, " done_cycle"}, dc, exp_cyc);
      chk({nm, " prod"}, PROD, exp);
      tick();
      chk({nm, " after_done"}, {done, busy, PROD}, {1'b0, 1'b0, exp});
    end
  endtask

  typedef struct {
    string       nm;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] prod;
    int          cyc;
    int          stall_at;
    int          stall_len;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int dc;
    int npulse;
    logic [31:0] exp2;

    vecs[0] = '{"v3x5",    16'h0003, 16'h0005, 32'h0000000F, 49, 0, 0};
    vecs[1] = '{"vffxff",  16'hFFFF, 16'hFFFF, 32'hFFFE0001, 49, 0, 0};
    vecs[2] = '{"vzero",   16'h1234, 16'h0000, 32'h00000000, 49, 0, 0};
    vecs[3] = '{"vstall",  16'h00FF, 16'h0101, 32'h0000FFFF, 54, 2, 5};
    vecs[4] = '{"vmsb",    16'h8000, 16'h8000, 32'h40000000, 49, 0, 0};
    vecs[5] = '{"vffx1",   16'hFFFF, 16'h0001, 32'h0000FFFF, 49, 0, 0};
    vecs[6] = '{"v1xff",   16'h0001, 16'hFFFF, 32'h0000FFFF, 49, 0, 0};

    // Reset with RDY low: reset must still take effect.
    reset_n = 1'b0; RDY = 1'b0; start = 1'b0; A = 16'h0; B = 16'h0;
    tick();
    tick();
    chk("reset_state", {busy, done, PROD}, {1'b0, 1'b0, 32'h0});
    chk("reset_alu", {alu_op, alu_right, alu_AI, alu_BI, alu_CI},
        {4'b1111, 1'b0, 16'h0, 16'h0, 1'b0});
    reset_n = 1'b1; RDY = 1'b1;
    tick();
    chk("idle_hold", {busy, done}, {1'b0, 1'b0});

    for (int i = 0; i < 7; i++)
      run_op(vecs[i].nm, vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].cyc,
             vecs[i].stall_at, vecs[i].stall_len, 1'b0);

    // Start held high for the whole operation, with new operands at cycle 10.
    // The second operation is accepted in IDLE, at cycle 50.
    run_op("hold", 16'h0003, 16'h0005, 32'h0000000F, 49, 0, 0, 1'b1);
    tick();
    chk("hold_accept", {busy, PROD}, {1'b1, 32'h00005555});
    start = 1'b0;
    exp2 = 32'(16'hAAAA) * 32'(16'h5555);
    dc = -1;
    for (int n = 2; n <= 120 && dc < 0; n++) begin
      tick();
      if (done) dc = n;
    end
    chk("hold_second_cycle", dc, 49);
    chk("hold_second_prod", PROD, exp2);
    tick();

    // Reset in the middle of an operation: it aborts with no done pulse.
    A = 16'h1234; B = 16'h5678; start = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      start = 1'b0;
    end
    reset_n = 1'b0;
    tick();
    chk("midreset", {busy, done, PROD}, {1'b0, 1'b0, 32'h0});
    reset_n = 1'b1;
    npulse = 0;
    for (int n = 0; n < 60; n++) begin
      tick();
      if (done || busy) npulse++;
    end
    chk("midreset_no_done", npulse, 0);
    run_op("post_reset", 16'h0102, 16'h0304, 32'h00030A08, 49, 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001: The block SHALL have parameter dw, default 16, setting the ALU data width (8 for 6502, 16 for 65Org16).
REQ-002: The port list SHALL be as follows, one port per line, in this order:
- clk  input  1  single clock; all state changes on its rising edge.
- reset_n  input  1  reset; synchronous and active-low.
- RDY  input  1  global stall; when 0, all internal state holds.
- start  input  1  request a multiply; sampled only in IDLE.
- A  input  dw  multiplicand.
- B  input  dw  multiplier.
- busy  output  1  high in ADD, SHIFT and WB.
- done  output  1  one-cycle completion strobe (DONE state).
- PROD  output  2*dw  unsigned product {P,Q}.
- alu_op  output  4  ALU operation select.
- alu_right  output  1  ALU right-shift select.
- alu_AI  output  dw  ALU operand A.
- alu_BI  output  dw  ALU operand B.
- alu_CI  output  1  ALU carry in.
- alu_RDY  output  1  ALU clock enable.
- alu_OUT  input  dw  registered ALU result (one cycle after drive).
- alu_CO  input  1  registered ALU carry out.

Function
REQ-003: The block SHALL compute the unsigned product A*B by shift-add over dw iterations, using only the shared ALU for addition and shifting.
REQ-004: The block SHALL hold internal registers M (dw), P (dw, high half), Q (dw, low half/multiplier) and cnt (log2(dw)+1 bits).
REQ-005: The block SHALL implement exactly five states: IDLE, ADD, SHIFT, WB, DONE.
REQ-006: In IDLE with start=1 and RDY=1, the block SHALL load M<=A, P<=0, Q<=B, cnt<=0 and go to ADD.
- In IDLE with start=0, the state SHALL be held.
REQ-007: In ADD, the block SHALL drive alu_right=0, alu_AI=P and alu_CI=0, and then go to SHIFT.
- If Q[0]=1: alu_op=4'b0011, alu_BI=M.
- If Q[0]=0: alu_op=4'b1111, alu_BI=0.
REQ-008: In SHIFT, the block SHALL drive alu_right=1, alu_op=4'b1111, alu_AI=alu_OUT, alu_CI=alu_CO and alu_BI=0, and then go to WB.
- ALU response: OUT={carry,sum[dw-1:1]}, CO=sum[0].
REQ-009: In WB, the block SHALL load P<=alu_OUT, Q<={alu_CO,Q[dw-1:1]} and cnt<=cnt+1.
- Next state: DONE if cnt=dw-1, else ADD.
REQ-010: In DONE, the block SHALL assert done=1 for one cycle and then return to IDLE.
REQ-011: In IDLE, WB and DONE, the block SHALL drive alu_op=4'b1111, alu_right=0, alu_AI=0, alu_BI=0 and alu_CI=0.
REQ-012: PROD SHALL equal {P,Q} at all times and SHALL hold its value after DONE until the next accepted start.
REQ-013: alu_RDY SHALL equal RDY combinationally.
REQ-014: With RDY=0, state, M, P, Q and cnt SHALL hold, and ALU-facing outputs SHALL keep the current state's values (the ALU is also frozen, so alu_OUT/alu_CO remain valid).
REQ-015: Latency with RDY held at 1: start accepted at cycle 0, iteration k ADD at cycle 1+3k, done=1 at cycle 3*dw+1 (cycle 49 for dw=16). Each RDY=0 cycle adds exactly one cycle.
REQ-016: start SHALL be ignored in ADD, SHIFT, WB and DONE, with no queuing.
REQ-017: The carry out of the top bit SHALL never be lost: the SHIFT step carries the add carry into P[dw-1].

Reset
REQ-018: When reset_n=0 at a rising edge of clk, regardless of RDY, the block SHALL go to IDLE with M=0, P=0, Q=0, cnt=0, busy=0, done=0 and ALU outputs at IDLE values.
REQ-019: A reset asserted mid-operation SHALL abort the operation with no done pulse, and PROD SHALL read 0.

Verification
REQ-020: dw=16, A=0x0003, B=0x0005, start pulse, RDY=1 -> done at cycle 49, PROD=0x0000000F.
REQ-021: A=0xFFFF, B=0xFFFF -> PROD=0xFFFE0001; checks carry into P[15] on every iteration.
REQ-022: A=0x1234, B=0x0000 -> PROD=0x00000000, with alu_op=4'b1111 in every ADD cycle.
REQ-023: A=0x00FF, B=0x0101, RDY=0 for 5 cycles starting in a SHIFT state -> done at cycle 54, PROD=0x0000FFFF.
REQ-024: Start held high throughout an operation, and a second start with new operands at cycle 10 -> result reflects the first operands only; exactly one done pulse, then the next operation is accepted from IDLE.
REQ-025: reset_n=0 at cycle 20 of an operation -> next cycle busy=0, done=0, PROD=0; a new start then completes normally.
